// File: rtl/proc_pkg.sv
// Shared types and constants for the fetch pipeline: PC/instruction widths,
// the fetch packet handed to decode, and the fault instruction.
package proc_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
    logic   fault;
  } fetch_pkt_t;

  localparam instr_t NOP_INSTR = 32'h0000_0000;

  // A PC beyond the implemented memory faults instead of reading.
  function automatic logic pc_out_of_range(input pc_t pc, input int depth);
    return (int'(pc) >= depth);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Synchronous instruction RAM: one registered read port and one write port,
// read-first so a same-cycle write is not visible to the concurrent read.
module instr_mem
  import proc_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  instr_t mem_q [DEPTH];
  instr_t rdata_q;

  // Read and write share the edge; the nonblocking update yields the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
    if (we && !pc_out_of_range(waddr, DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: accepts PCs, reads the instruction RAM with 2-cycle latency and
// buffers {pc, instr, fault} in a credit-managed FIFO in front of decode.
module instr_fetch_stage
  import proc_pkg::*;
#(
  parameter int     IMEM_DEPTH = 64,
  parameter int     FIFO_DEPTH = 3,
  parameter instr_t NOP_INSTR  = proc_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               clkreset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  fetch_pkt_t fifo_q [FIFO_DEPTH];
  fetch_pkt_t fifo_d [FIFO_DEPTH];
  ptr_t       head_q, head_d;
  ptr_t       tail_q, tail_d;
  cnt_t       count_q, count_d;
  logic       inflight_q, inflight_d;
  pc_t        req_pc_q, req_pc_d;
  logic       req_fault_q, req_fault_d;

  instr_t     mem_rdata_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;
  logic       mem_re_s;
  logic       mem_we_s;
  fetch_pkt_t land_pkt_s;
  fetch_pkt_t head_pkt_s;
  fetch_pkt_t out_pkt_s;
  logic [SUM_W-1:0] credits_used_s;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Each in-flight read holds a FIFO slot, so a landing result always fits.
  assign credits_used_s = SUM_W'(count_q) + SUM_W'(inflight_q);
  assign pc_ready       = ~clkreset & ~flush & (credits_used_s < SUM_W'(FIFO_DEPTH));
  assign accept_s       = pc_valid & pc_ready;
  assign mem_re_s       = accept_s & ~pc_out_of_range(pc_in, IMEM_DEPTH);
  assign mem_we_s       = imem_we & ~clkreset;

  assign out_valid  = (count_q != CNT_W'(0));
  assign pop_s      = out_valid & out_ready;
  assign push_s     = inflight_q & ~flush;
  assign head_pkt_s = fifo_q[head_q];
  assign out_pkt_s  = out_valid ? head_pkt_s : {$bits(fetch_pkt_t){1'b0}};
  assign out_pc     = out_pkt_s.pc;
  assign out_instr  = out_pkt_s.instr;
  assign out_fault  = out_pkt_s.fault;

  instr_mem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .re    (mem_re_s),
    .raddr (pc_in),
    .rdata (mem_rdata_s)
  );

  // Assemble the packet for the read that lands this cycle.
  always_comb begin
    land_pkt_s.pc    = req_pc_q;
    land_pkt_s.fault = req_fault_q;
    if (req_fault_q) begin
      land_pkt_s.instr = NOP_INSTR;
    end else begin
      land_pkt_s.instr = mem_rdata_s;
    end
  end

  // Request tracking: remember the PC and fault status of the launched read.
  always_comb begin
    inflight_d = accept_s;
    if (accept_s) begin
      req_pc_d    = pc_in;
      req_fault_d = pc_out_of_range(pc_in, IMEM_DEPTH);
    end else begin
      req_pc_d    = req_pc_q;
      req_fault_d = req_fault_q;
    end
  end

  // FIFO next state; flush wins over any push or pop in the same cycle.
  always_comb begin
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_d[tail_q] = land_pkt_s;
        tail_d         = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge clkreset) begin
    if (clkreset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {$bits(fetch_pkt_t){1'b0}};
      end
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      inflight_q  <= 1'b0;
      req_pc_q    <= {ADDR_W{1'b0}};
      req_fault_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      req_pc_q    <= req_pc_d;
      req_fault_q <= req_fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a driver pushes expected packets,
// a negedge monitor pops and compares them against the presented output.
module tb_instr_fetch_stage;
  import proc_pkg::*;

  localparam int DEPTH = 48;

  logic         clk = 1'b0;
  logic         clkreset;
  logic [5:0]   pc_in;
  logic         pc_valid;
  logic         pc_ready;
  logic         flush;
  logic         imem_we;
  logic [5:0]   imem_waddr;
  logic [31:0]  imem_wdata;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_pc;
  logic [31:0]  out_instr;
  logic         out_fault;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .IMEM_DEPTH (DEPTH),
    .FIFO_DEPTH (3),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .clkreset   (clkreset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_fault  (out_fault)
  );

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [64];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          pop_now = 1'b0;
  logic        acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; called just after a posedge, returns just after the next.
  task automatic step(input logic v, input int p, input logic fl, input logic we,
                      input int wa, input logic [31:0] wd, input logic rdy, output logic accepted);
    logic exp_rdy;
    exp_t e;
    pc_valid   = v;
    pc_in      = 6'(p);
    flush      = fl;
    imem_we    = we;
    imem_waddr = 6'(wa);
    imem_wdata = wd;
    out_ready  = rdy;
    @(negedge clk);
    #1;
    // Outstanding = accepted but not yet consumed; the pop announced this cycle has not happened yet.
    exp_rdy = !fl && ((sb_q.size() + int'(pop_now)) < 3);
    chk("pc_ready", 64'(pc_ready), 64'(exp_rdy));
    accepted = v && exp_rdy;
    if (accepted) begin
      e.pc    = 6'(p);
      e.fault = (p >= DEPTH);
      e.instr = (p >= DEPTH) ? 32'h0000_0000 : mem_m[p];
      e.due   = cyc + 2;
      sb_q.push_back(e);
    end
    if (we && wa < DEPTH) mem_m[wa] = wd;
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 32'h0, rdy, a);
  endtask

  // Monitor: compare the presented head against the oldest expected packet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      pop_now = 1'b0;
      if (clkreset === 1'b0) begin
        if (out_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("out_valid_unexpected", 64'(out_valid), 64'd0);
          end else begin
            e = sb_q[0];
            chk("latency_not_early", 64'(cyc >= e.due), 64'd1);
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_instr", 64'(out_instr), 64'(e.instr));
            chk("out_fault", 64'(out_fault), 64'(e.fault));
            if (out_ready === 1'b1) begin
              void'(sb_q.pop_front());
              pop_now = 1'b1;
            end
          end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          chk("out_valid_due", 64'(out_valid), 64'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int idx;
    clkreset   = 1'b1;
    pc_valid   = 1'b0;
    pc_in      = 6'd0;
    flush      = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = 6'd0;
    imem_wdata = 32'h0;
    out_ready  = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_fault", 64'(out_fault), 64'd0);
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clkreset = 1'b0;

    // Preload every implemented word; words 0..3 carry the A-pattern.
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 0, 1'b0, 1'b1, a, (a < 4) ? (32'hA0A0_0000 + 32'(a)) : $urandom, 1'b1, acc);
    end

    // Back-to-back fetch of 0..3 with decode always ready.
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    idle(4, 1'b1);

    // Decode stalled for 6 cycles: credits stop acceptance at 3.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, idx, 1'b0, 1'b0, 0, 32'h0, 1'b0, acc);
      if (acc) idx++;
    end
    for (int i = 0; i < 10 && idx < 4; i++) begin
      step(1'b1, idx, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
      if (acc) idx++;
    end
    idle(6, 1'b1);

    // Flush one cycle after accepting pc 5, then fetch pc 9.
    step(1'b1, 5, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 6, 1'b1, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 9, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    idle(4, 1'b1);

    // Read-first: write B7 over C7 while fetching 7, then refetch.
    step(1'b0, 0, 1'b0, 1'b1, 7, 32'hC7C7_C7C7, 1'b1, acc);
    step(1'b1, 7, 1'b0, 1'b1, 7, 32'hB7B7_B7B7, 1'b1, acc);
    step(1'b1, 7, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    idle(4, 1'b1);

    // Fault boundary and PC wrap.
    step(1'b1, 50, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 47, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 48, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 63, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    step(1'b1, 0, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    idle(4, 1'b1);

    // Randomized traffic: backpressure, flushes, writes (some out of range).
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 63), $urandom,
           $urandom_range(0, 3) != 0, acc);
    end
    idle(6, 1'b1);

    // Reset pulse with two entries buffered; the write during reset is ignored.
    step(1'b1, 1, 1'b0, 1'b0, 0, 32'h0, 1'b0, acc);
    step(1'b1, 2, 1'b0, 1'b0, 0, 32'h0, 1'b0, acc);
    idle(2, 1'b0);
    clkreset   = 1'b1;
    imem_we    = 1'b1;
    imem_waddr = 6'd0;
    imem_wdata = 32'hDEAD_BEEF;
    pc_valid   = 1'b1;
    pc_in      = 6'd3;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_pc_ready", 64'(pc_ready), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("rst_held_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_held_out_valid", 64'(out_valid), 64'd0);
    clkreset = 1'b0;
    imem_we  = 1'b0;
    pc_valid = 1'b0;
    step(1'b1, 0, 1'b0, 1'b0, 0, 32'h0, 1'b1, acc);
    idle(5, 1'b1);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
